uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_tick.sv | 46 ++++
 rtl/uart_tx.sv | 174 +++++++++++++++++
 tb/tb_uart_tx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants, state encodings and parity helper.
// Optional parity framing is selected with the UART_TX_PARITY_EN macro.
package uart_pkg;

    localparam int CLK_HZ_DEFAULT   = 100_000_000;
    localparam int BIT_RATE_DEFAULT = 9600;
    localparam int DATA_W           = 8;

`ifdef UART_TX_PARITY_EN
    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] S_START  = 3'd1;
    localparam logic [STATE_W-1:0] S_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] S_STOP   = 3'd3;
    localparam logic [STATE_W-1:0] S_PARITY = 3'd4;

    function automatic logic even_parity(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction
`else
    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] S_START = 2'd1;
    localparam logic [STATE_W-1:0] S_DATA  = 2'd2;
    localparam logic [STATE_W-1:0] S_STOP  = 2'd3;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: emits a one-cycle tick every CLKS_PER_BIT enabled cycles.
// Shared between the UART transmitter and receiver.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic nreset_i,
    input  logic enable_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_s;

    assign tick_s = enable_i && !clear_i && (cnt_q == CNT_LAST);
    assign tick_o = tick_s;

    // Next count: clear wins, wrap on tick, otherwise count while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_s) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, 1 or 2 stop bits, valid/ready input.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = CLK_HZ_DEFAULT,
    parameter int BIT_RATE  = BIT_RATE_DEFAULT,
    parameter int STOP_BITS = 1
) (
    input  logic              clk_i,
    input  logic              nreset_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CLKS_PER_BIT = CLK_HZ / BIT_RATE;
    localparam logic [2:0] LAST_DATA_BIT = 3'd7;
    localparam logic [2:0] LAST_STOP_BIT = (STOP_BITS == 2) ? 3'd1 : 3'd0;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [DATA_W-1:0]  shift_q;
    logic [DATA_W-1:0]  shift_d;
    logic [2:0]         bit_cnt_q;
    logic [2:0]         bit_cnt_d;
    logic               tx_q;
    logic               tx_d;
    logic               ready_q;
    logic               ready_d;
    logic               done_q;
    logic               done_d;
    logic               bit_tick_s;
    logic               baud_en_s;
    logic               baud_clr_s;
`ifdef UART_TX_PARITY_EN
    logic               parity_q;
    logic               parity_d;
`endif

    assign baud_en_s  = (state_q != S_IDLE);
    assign baud_clr_s = (state_q == S_IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk_i    (clk_i),
        .nreset_i (nreset_i),
        .enable_i (baud_en_s),
        .clear_i  (baud_clr_s),
        .tick_o   (bit_tick_s)
    );

    // Frame sequencing; tx is looked ahead from the next state so it changes on the handshake edge.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (valid_i && ready_q) begin
                    state_d   = S_START;
                    shift_d   = data_i;
                    bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = even_parity(data_i);
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bit_tick_s) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (bit_tick_s) begin
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    if (bit_cnt_q == LAST_DATA_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                        bit_cnt_d = 3'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_tick_s) begin
                    state_d = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                if (bit_tick_s) begin
                    if (bit_cnt_q == LAST_STOP_BIT) begin
                        state_d   = S_IDLE;
                        bit_cnt_d = 3'd0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d   = S_IDLE;
                bit_cnt_d = 3'd0;
            end
        endcase

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // State and output registers; reset drives the line idle-high immediately.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= 3'd0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign tx_o    = tx_q;
    assign ready_o = ready_q;
    assign busy_o  = !ready_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: random bytes, line receiver monitor, 2-stop-bit instance.
module tb_uart_tx;

    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME  = (10 + PAR) * CPB;
    localparam int FRAME2 = (11 + PAR) * CPB;
    localparam int NSLOT  = 10 + PAR;
    localparam int MAXC   = 8192;

    typedef struct {
        logic [7:0] d;
        int         t0;
    } frame_t;

    logic       clk = 1'b0;
    logic       nreset;
    logic       valid, valid2;
    logic [7:0] data, data2;
    logic       ready, tx, busy, done;
    logic       ready2, tx2, busy2, done2;

    int     cyc = 0;
    int     n_checks = 0;
    int     n_errors = 0;
    int     free_at = 0;
    frame_t exp_q[$];
    bit     busy_map [MAXC];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .STOP_BITS(1)) dut (
        .clk_i(clk), .nreset_i(nreset), .valid_i(valid), .ready_o(ready),
        .data_i(data), .tx_o(tx), .busy_o(busy), .done_o(done));

    uart_tx #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .STOP_BITS(2)) dut2 (
        .clk_i(clk), .nreset_i(nreset), .valid_i(valid2), .ready_o(ready2),
        .data_i(data2), .tx_o(tx2), .busy_o(busy2), .done_o(done2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level for a frame of byte d, pos cycles after the start edge.
    function automatic logic line_bit(input logic [7:0] d, input int pos);
        int slot;
        slot = pos / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot-1];
        if (PAR == 1 && slot == 9) return ^d;
        return 1'b1;
    endfunction

    // Offer byte d; the model predicts the accepting edge from the previous frame end.
    task automatic send(input logic [7:0] d, input bit hold);
        int t;
        frame_t f;
        valid = 1'b1;
        data  = d;
        t = (cyc + 1 > free_at) ? cyc + 1 : free_at;
        f.d  = d;
        f.t0 = t;
        exp_q.push_back(f);
        for (int c = t; c < t + FRAME && c < MAXC; c++) busy_map[c] = 1'b1;
        free_at = t + FRAME + 1;
        while (cyc < t) tick();
        if (!hold) valid = 1'b0;
    endtask

    // Monitor: recovers frames from tx and scores them against the queue on done.
    initial begin : monitor
        bit         rx_active = 1'b0;
        int         rx_pos = 0;
        int         rx_t0 = 0;
        logic [11:0] rx_bits = '0;
        frame_t     e;
        forever begin
            @(negedge clk);
            if (!nreset) begin
                rx_active = 1'b0;
            end else begin
                if (cyc < MAXC) begin
                    chk("ready", ready, !busy_map[cyc]);
                    chk("busy", busy, busy_map[cyc]);
                end
                if (!rx_active && tx == 1'b0) begin
                    rx_active = 1'b1;
                    rx_pos = 0;
                    rx_t0 = cyc;
                end
                if (rx_active) begin
                    if (rx_pos % CPB == CPB / 2) rx_bits[rx_pos / CPB] = tx;
                    rx_pos++;
                    if (rx_pos == FRAME) rx_active = 1'b0;
                end
                if (done) begin
                    chk("done_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("rx_data", rx_bits[8:1], e.d);
                        chk("start_cycle", rx_t0, e.t0);
                        chk("done_cycle", cyc, e.t0 + FRAME);
                        chk("start_bit", rx_bits[0], 0);
                        chk("stop_bit", rx_bits[NSLOT-1], 1);
                        if (PAR == 1) chk("parity_bit", rx_bits[9], ^e.d);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int t;
        int gap;
        logic [7:0] rd;
        nreset = 1'b0;
        valid  = 1'b0;
        valid2 = 1'b0;
        data   = 8'h00;
        data2  = 8'h00;
        repeat (3) tick();
        chk("rst_tx", tx, 1);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tx2", tx2, 1);
        nreset = 1'b1;
        free_at = cyc + 1;

        send(8'hA5, 1'b0);
        repeat (3) tick();

        send(8'h00, 1'b1);
        send(8'hFF, 1'b0);
        repeat (2) tick();

        // Pulse a different byte in the middle of a frame; it must not be taken.
        send(8'h55, 1'b0);
        repeat (30) tick();
        valid = 1'b1;
        data  = 8'h3C;
        tick();
        valid = 1'b0;
        while (cyc < free_at) tick();
        repeat (2) tick();

        send(8'h81, 1'b0);
        repeat (45) tick();
        #2;
        nreset = 1'b0;
        exp_q.delete();
        for (int c = cyc; c < cyc + FRAME + 2 && c < MAXC; c++) busy_map[c] = 1'b0;
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_ready", ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        repeat (3) tick();
        nreset = 1'b1;
        free_at = cyc + 1;
        send(8'h7E, 1'b0);

        for (int i = 0; i < 12; i++) begin
            rd  = 8'($urandom);
            gap = $urandom_range(0, 3);
            send(rd, gap == 0);
            repeat (gap) tick();
        end
        valid = 1'b0;
        send(8'h07, 1'b0);

        for (int k = 0; k < 400 && exp_q.size() != 0; k++) tick();
        chk("queue_drained", exp_q.size(), 0);
        repeat (2) tick();

        // Two-stop-bit instance: check the whole line waveform cycle by cycle.
        t = cyc + 1;
        valid2 = 1'b1;
        data2  = 8'h12;
        tick();
        valid2 = 1'b0;
        chk("s2_accept_cycle", cyc, t);
        for (int p = 0; p <= FRAME2; p++) begin
            chk("s2_tx", tx2, line_bit(8'h12, p));
            chk("s2_done", done2, p == FRAME2);
            chk("s2_ready", ready2, p == FRAME2);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
